// File: rtl/sdf_bf2_if.sv
// Streaming complex sample bus between an SDF butterfly stage and its producer/consumer.
interface sdf_bf2_if #(
  parameter int unsigned WIDTH = 16
);
  logic                    i_valid;
  logic                    i_start;
  logic signed [WIDTH-1:0] i_rX;
  logic signed [WIDTH-1:0] i_iX;
  logic                    o_valid;
  logic signed [WIDTH:0]   o_rZ;
  logic signed [WIDTH:0]   o_iZ;

  modport master (
    output i_valid, i_start, i_rX, i_iX,
    input  o_valid, o_rZ, o_iZ
  );

  modport slave (
    input  i_valid, i_start, i_rX, i_iX,
    output o_valid, o_rZ, o_iZ
  );
endinterface

// File: rtl/sdf_bf2_stage.sv
// Radix-2^2 single-path delay-feedback butterfly stage (BF2I or BF2II by MODE).
// Streams one complex sample per valid cycle; output is registered with one bit of growth.
module sdf_bf2_stage #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned MODE  = 0
) (
  input  logic      clk,
  input  logic      rst,
  sdf_bf2_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1 + MODE;
  localparam int unsigned OW = WIDTH + 1;

  logic [CW-1:0]        cnt_q, cnt_d, cnt_eff;
  logic                 primed_q;
  logic                 o_valid_q;
  logic signed [OW-1:0] o_r_q, o_i_q;
  logic signed [OW-1:0] dl_r_q [DEPTH];
  logic signed [OW-1:0] dl_i_q [DEPTH];

  logic                 ph, rot;
  logic signed [OW-1:0] x_r, x_i, xp_r, xp_i;
  logic signed [OW-1:0] head_r, head_i;
  logic signed [OW-1:0] out_r, out_i, din_r, din_i;

  // Frame position, optional -j rotation and the butterfly itself.
  always_comb begin
    cnt_eff = bus.i_start ? '0 : cnt_q;
    cnt_d   = cnt_eff + CW'(1);
    ph      = cnt_eff[AW];
    rot     = (MODE == 1) && ph && cnt_eff[CW-1];
    x_r     = OW'(bus.i_rX);
    x_i     = OW'(bus.i_iX);
    xp_r    = x_r;
    xp_i    = x_i;
    if (rot) begin
      xp_r = x_i;
      xp_i = -x_r;
    end
    head_r = dl_r_q[DEPTH-1];
    head_i = dl_i_q[DEPTH-1];
    out_r  = head_r;
    out_i  = head_i;
    din_r  = x_r;
    din_i  = x_i;
    if (ph) begin
      out_r = head_r + xp_r;
      out_i = head_i + xp_i;
      din_r = head_r - xp_r;
      din_i = head_i - xp_i;
    end
  end

  // All state advances only on accepted samples; reset wins over a coincident sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      primed_q  <= 1'b0;
      o_valid_q <= 1'b0;
      o_r_q     <= '0;
      o_i_q     <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        dl_r_q[k] <= '0;
        dl_i_q[k] <= '0;
      end
    end else begin
      o_valid_q <= bus.i_valid & (primed_q | ph);
      if (bus.i_valid) begin
        cnt_q <= cnt_d;
        if (ph) primed_q <= 1'b1;
        o_r_q     <= out_r;
        o_i_q     <= out_i;
        dl_r_q[0] <= din_r;
        dl_i_q[0] <= din_i;
        for (int unsigned k = 1; k < DEPTH; k++) begin
          dl_r_q[k] <= dl_r_q[k-1];
          dl_i_q[k] <= dl_i_q[k-1];
        end
      end
    end
  end

  assign bus.o_valid = o_valid_q;
  assign bus.o_rZ    = o_r_q;
  assign bus.o_iZ    = o_i_q;
endmodule

// File: tb/tb_sdf_bf2_stage.sv
// Directed bench for sdf_bf2_stage: three configurations sharing one clock and reset.
module tb_sdf_bf2_stage;
  localparam int unsigned W = 16;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;
  int          sel;

  sdf_bf2_if #(.WIDTH(W)) b1 ();
  sdf_bf2_if #(.WIDTH(W)) b2 ();
  sdf_bf2_if #(.WIDTH(W)) b3 ();

  sdf_bf2_stage #(.WIDTH(W), .DEPTH(2), .MODE(0)) u_d2_bf2i  (.clk(clk), .rst(rst), .bus(b1));
  sdf_bf2_stage #(.WIDTH(W), .DEPTH(1), .MODE(1)) u_d1_bf2ii (.clk(clk), .rst(rst), .bus(b2));
  sdf_bf2_stage #(.WIDTH(W), .DEPTH(1), .MODE(0)) u_d1_bf2i  (.clk(clk), .rst(rst), .bus(b3));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Apply one cycle of input to the selected bus, then sample 1 time unit after the edge.
  task automatic drv(input bit v, input bit s, input int r, input int i);
    b1.i_valid = v && (sel == 1);
    b2.i_valid = v && (sel == 2);
    b3.i_valid = v && (sel == 3);
    b1.i_start = s; b2.i_start = s; b3.i_start = s;
    b1.i_rX = W'(r); b2.i_rX = W'(r); b3.i_rX = W'(r);
    b1.i_iX = W'(i); b2.i_iX = W'(i); b3.i_iX = W'(i);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input bit v, input int r, input int i);
    logic                ov;
    logic signed [W:0]   orr, oi;
    case (sel)
      1:       begin ov = b1.o_valid; orr = b1.o_rZ; oi = b1.o_iZ; end
      2:       begin ov = b2.o_valid; orr = b2.o_rZ; oi = b2.o_iZ; end
      default: begin ov = b3.o_valid; orr = b3.o_rZ; oi = b3.o_iZ; end
    endcase
    chk({tag, ".v"}, 32'(ov), 32'(v));
    if (v) begin
      chk({tag, ".r"}, 32'(orr), r);
      chk({tag, ".i"}, 32'(oi), i);
    end
  endtask

  task automatic step(input string tag, input bit v, input bit s, input int r, input int i,
                      input bit ev, input int er, input int ei);
    drv(v, s, r, i);
    expect_out(tag, ev, er, ei);
  endtask

  // Frame 1,2,3,4 then the fill of a zero frame; optional idle cycle after each sample.
  task automatic run_t1(input string tag, input bit gaps);
    int      xr [6] = '{1, 2, 3, 4, 0, 0};
    bit      xs [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    bit      ev [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int      er [6] = '{0, 0, 4, 6, -2, -2};
    for (int k = 0; k < 6; k++) begin
      step($sformatf("%s_s%0d", tag, k), 1'b1, xs[k], xr[k], 0, ev[k], er[k], 0);
      if (gaps) step($sformatf("%s_g%0d", tag, k), 1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    sel = 1;
    drv(1'b0, 1'b0, 0, 0);
    drv(1'b0, 1'b0, 0, 0);
    chk("rst.v", 32'(b1.o_valid), 0);
    chk("rst.r", 32'(b1.o_rZ), 0);
    chk("rst.i", 32'(b1.o_iZ), 0);
    rst = 1'b0;

    // BF2II, DEPTH=1: quarter-3 sample rotated by -j
    sel = 2;
    step("t2a", 1'b1, 1'b1, 1, 0, 1'b0, 0,  0);
    step("t2b", 1'b1, 1'b0, 1, 0, 1'b1, 2,  0);
    step("t2c", 1'b1, 1'b0, 1, 0, 1'b1, 0,  0);
    step("t2d", 1'b1, 1'b0, 1, 0, 1'b1, 1, -1);
    step("t2e", 1'b1, 1'b1, 0, 0, 1'b1, 1,  1);

    // Extreme negative inputs need the full growth bit
    sel = 3;
    step("t3a", 1'b1, 1'b1, -32768, 0, 1'b0, 0,      0);
    step("t3b", 1'b1, 1'b0, -32768, 0, 1'b1, -65536, 0);
    chk("t3raw", 32'(b3.o_rZ[W:0]), 32'h0001_0000);
    step("t3c", 1'b1, 1'b1, 0, 0, 1'b1, 0, 0);

    sel = 1;
    run_t1("t1", 1'b0);

    // Reset coincident with a valid sample drops the sample
    rst = 1'b1;
    step("rstw", 1'b1, 1'b1, 99, 7, 1'b0, 0, 0);
    chk("rstw.r", 32'(b1.o_rZ), 0);
    rst = 1'b0;

    run_t1("t4", 1'b1);

    // Partial frame, then mid-frame reset and a fresh frame
    step("t5p0", 1'b1, 1'b1, 7, 0, 1'b1, 0,  0);
    step("t5p1", 1'b1, 1'b0, 8, 0, 1'b1, 0,  0);
    step("t5p2", 1'b1, 1'b0, 9, 0, 1'b1, 16, 0);
    rst = 1'b1;
    step("t5rst", 1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
    rst = 1'b0;
    run_t1("t5", 1'b0);

    // i_start alone is ignored; i_start on sample 2 realigns the frame
    step("t6n", 1'b0, 1'b1, 0,  0, 1'b0, 0,   0);
    step("t6a", 1'b1, 1'b0, 10, 0, 1'b1, 10,  0);
    step("t6b", 1'b1, 1'b0, 20, 0, 1'b1, 20,  0);
    step("t6c", 1'b1, 1'b1, 5,  0, 1'b1, -10, 0);
    step("t6d", 1'b1, 1'b1, 6,  0, 1'b1, -20, 0);
    step("t6e", 1'b1, 1'b0, 7,  0, 1'b1, 5,   0);
    step("t6f", 1'b1, 1'b0, 8,  0, 1'b1, 14,  0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
